rob: RTL and testbench

Reorder buffer sitting directly downstream of rename. Accepts renamed instructions in program order, assigns each a slot index, and records out-of-order completions from the backend. It retires completed instructions strictly in order. Each retired entry is presented to rename as the `rob_entry_t` that releases its physical register.

---
 rtl/rob_if.sv | 38 +++
 rtl/rob.sv | 113 +++++++++++
 tb/tb_rob.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// +--------------------------------------------------------------------------+
// | rob_pkg / squash_if : payload types and flush interface for the ROB       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package rob_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_valid;
    } si_t;

    typedef struct packed {
        logic [7:0] id;
        si_t        si;
        logic [5:0] prd;
    } di_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] pc;
        logic [4:0]  ard;
        logic [5:0]  prd;
        logic        needprf2arf;
    } rob_entry_t;

endpackage

interface squash_if;
    logic valid;

    modport master (output valid);
    modport slave  (input  valid);
endinterface

`default_nettype wire

// File: rtl/rob.sv
// +--------------------------------------------------------------------------+
// | rob : in-order allocate, out-of-order complete, in-order retire buffer   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module rob
    import rob_pkg::*;
#(
    parameter  int ROBSIZE  = 16,
    localparam int IDX_BITS = $clog2(ROBSIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  di_t                 di_i,
    input  logic                di_i_valid,
    output logic                di_i_ready,
    output logic [IDX_BITS-1:0] rob_idx_o,
    input  logic                complete_valid_i,
    input  logic [IDX_BITS-1:0] complete_idx_i,
    output rob_entry_t          retire_entry_o,
    output logic                retire_entry_o_valid,
    squash_if.slave             squash_io
);

    localparam logic [IDX_BITS:0]   CNT_FULL = (IDX_BITS+1)'(ROBSIZE);
    localparam logic [IDX_BITS:0]   CNT_ONE  = (IDX_BITS+1)'(1);
    localparam logic [IDX_BITS-1:0] PTR_ONE  = IDX_BITS'(1);

    logic [ROBSIZE-1:0]  valid_q;
    logic [ROBSIZE-1:0]  done_q;
    logic [IDX_BITS-1:0] head_q;
    logic [IDX_BITS-1:0] tail_q;
    logic [IDX_BITS:0]   count_q;
    logic [IDX_BITS:0]   count_d;
    rob_entry_t          mem_q [ROBSIZE];
    rob_entry_t          retire_entry_q;
    logic                retire_valid_q;

    logic       w_alloc;
    logic       w_retire;
    rob_entry_t w_new_entry;

    // Ready depends only on the registered count: a slot freed by this
    // cycle's retire becomes usable next cycle.
    assign di_i_ready = (count_q != CNT_FULL);
    assign rob_idx_o  = tail_q;
    assign w_alloc    = di_i_valid && di_i_ready;
    assign w_retire   = valid_q[head_q] && done_q[head_q];

    assign retire_entry_o       = retire_entry_q;
    assign retire_entry_o_valid = retire_valid_q;

    assign w_new_entry = '{id:          di_i.id,
                           pc:          di_i.si.pc,
                           ard:         di_i.si.rd,
                           prd:         di_i.prd,
                           needprf2arf: di_i.si.rd_valid};

    always_comb begin
        count_d = count_q;
        if (w_alloc && !w_retire) begin
            count_d = count_q + CNT_ONE;
        end else if (!w_alloc && w_retire) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc && !squash_io.valid) begin
            mem_q[tail_q] <= w_new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
            retire_entry_q <= '0;
        end else if (squash_io.valid) begin
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
        end else begin
            retire_valid_q <= w_retire;
            count_q        <= count_d;
            if (w_retire) begin
                retire_entry_q  <= mem_q[head_q];
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_ONE;
            end
            if (complete_valid_i && valid_q[complete_idx_i]) begin
                done_q[complete_idx_i] <= 1'b1;
            end
            // Allocation is applied last; the tail slot is never valid, so
            // it cannot collide with the retire or completion writes above.
            if (w_alloc) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + PTR_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob.sv
// +--------------------------------------------------------------------------+
// | tb_rob : randomized self-checking bench for rob with a queue-based model  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rob;
    import rob_pkg::*;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst;
    di_t        di;
    logic       di_valid;
    logic       di_ready;
    logic [3:0] rob_idx;
    logic       cv;
    logic [3:0] ci;
    rob_entry_t ret_e;
    logic       ret_v;

    squash_if sq_if ();

    rob #(.ROBSIZE(N)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .di_i                 (di),
        .di_i_valid           (di_valid),
        .di_i_ready           (di_ready),
        .rob_idx_o            (rob_idx),
        .complete_valid_i     (cv),
        .complete_idx_i       (ci),
        .retire_entry_o       (ret_e),
        .retire_entry_o_valid (ret_v),
        .squash_io            (sq_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int next_id = 1;

    // Reference model: in-flight instructions in program order
    typedef struct {
        rob_entry_t e;
        int         idx;
        bit         done;
    } ment_t;

    ment_t      mq[$];
    int         m_tail;
    bit         m_ret_v;
    rob_entry_t m_ret;

    function automatic rob_entry_t to_entry(input di_t d);
        rob_entry_t e;
        e.id          = d.id;
        e.pc          = d.si.pc;
        e.ard         = d.si.rd;
        e.prd         = d.prd;
        e.needprf2arf = d.si.rd_valid;
        return e;
    endfunction

    function automatic di_t rand_di();
        di_t d;
        d.id          = 8'(next_id);
        d.si.pc       = $urandom;
        d.si.rd       = 5'($urandom);
        d.si.rd_valid = 1'($urandom);
        d.prd         = 6'($urandom);
        next_id++;
        return d;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tail  = 0;
        m_ret_v = 0;
        m_ret   = '0;
    endtask

    // Apply inputs for one cycle, advance the model, and land #1 after the edge
    task automatic drive_cycle(input logic v, input di_t d, input logic c,
                               input logic [3:0] cidx, input logic sq);
        bit    alloc;
        bit    ret;
        ment_t n;
        di_valid    = v;
        di          = d;
        cv          = c;
        ci          = cidx;
        sq_if.valid = sq;
        if (sq) begin
            mq.delete();
            m_tail  = 0;
            m_ret_v = 0;
        end else begin
            alloc = v && (mq.size() < N);
            ret   = (mq.size() > 0) && mq[0].done;
            if (c) begin
                foreach (mq[i]) if (mq[i].idx == int'(cidx)) mq[i].done = 1;
            end
            m_ret_v = ret;
            if (ret) begin
                m_ret = mq[0].e;
                void'(mq.pop_front());
            end
            if (alloc) begin
                n.e    = to_entry(d);
                n.idx  = m_tail;
                n.done = 0;
                mq.push_back(n);
                m_tail = (m_tail + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        drive_cycle(1'b0, '0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        di_valid    = 1'b0;
        di          = '0;
        cv          = 1'b0;
        ci          = '0;
        sq_if.valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (di_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", di_ready); end
        checks++; if (rob_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d exp 0", rob_idx); end
        checks++; if (ret_v !== 1'b0) begin errors++; $display("FAIL reset_ret_v: got %b exp 0", ret_v); end
        checks++; if (ret_e !== '0) begin errors++; $display("FAIL reset_ret_e: got %h exp 0", ret_e); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        di_t d;
        do_reset();
        for (int i = 0; i < N; i++) begin
            checks++; if (rob_idx !== 4'(i)) begin errors++; $display("FAIL fill_idx: got %0d exp %0d", rob_idx, i); end
            d = rand_di();
            drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        end
        checks++; if (di_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b exp 0", di_ready); end
        d = rand_di();
        drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        checks++; if (dut.count_q !== 5'd16) begin errors++; $display("FAIL fill_17th_count: got %0d exp 16", dut.count_q); end
        checks++; if (rob_idx !== 4'd0) begin errors++; $display("FAIL fill_17th_idx: got %0d exp 0", rob_idx); end
        idle();
        checks++; if (ret_v !== 1'b0) begin errors++; $display("FAIL fill_no_retire: got %b exp 0", ret_v); end
    endtask

    task automatic test_out_of_order();
        logic [7:0] ids [3];
        int         got_id[$];
        int         got_cyc[$];
        int         c_a;
        logic [3:0] seq_idx [3];
        di_t        d;
        seq_idx[0] = 4'd2; seq_idx[1] = 4'd0; seq_idx[2] = 4'd1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = rand_di();
            ids[i] = d.id;
            drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        end
        c_a = 0;
        for (int s = 0; s < 9; s++) begin
            if (s == 1) c_a = cyc;
            if (s < 3) drive_cycle(1'b0, '0, 1'b1, seq_idx[s], 1'b0);
            else idle();
            checks++; if (ret_v !== 1'(m_ret_v)) begin errors++; $display("FAIL ooo_ret_v: got %b exp %b at step %0d", ret_v, m_ret_v, s); end
            if (ret_v === 1'b1) begin
                got_id.push_back(int'(ret_e.id));
                got_cyc.push_back(cyc);
            end
        end
        checks++;
        if (got_id.size() != 3) begin
            errors++; $display("FAIL ooo_pulses: got %0d exp 3", got_id.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (got_id[k] != int'(ids[k])) begin errors++; $display("FAIL ooo_order: pulse %0d got id %0d exp %0d", k, got_id[k], ids[k]); end
                checks++; if (got_cyc[k] != c_a + 2 + k) begin errors++; $display("FAIL ooo_timing: pulse %0d got cycle %0d exp %0d", k, got_cyc[k], c_a + 2 + k); end
            end
        end
    endtask

    task automatic test_full_retire();
        di_t        d;
        logic [7:0] first_id;
        do_reset();
        first_id = 8'(next_id);
        for (int i = 0; i < N; i++) begin
            d = rand_di();
            drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        end
        drive_cycle(1'b0, '0, 1'b1, 4'd0, 1'b0);
        checks++; if (di_ready !== 1'b0) begin errors++; $display("FAIL full_ready_decision: got %b exp 0", di_ready); end
        idle();
        checks++; if (di_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %b exp 1", di_ready); end
        checks++; if (ret_v !== 1'b1 || ret_e.id !== first_id) begin errors++; $display("FAIL full_retire: got v=%b id=%0d exp v=1 id=%0d", ret_v, ret_e.id, first_id); end
        checks++; if (rob_idx !== 4'd0) begin errors++; $display("FAIL full_free_idx: got %0d exp 0", rob_idx); end
        d = rand_di();
        drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        checks++; if (di_ready !== 1'b0 || rob_idx !== 4'd1) begin errors++; $display("FAIL full_realloc: got ready=%b idx=%0d exp ready=0 idx=1", di_ready, rob_idx); end
        idle();
        checks++; if (ret_v !== 1'b0) begin errors++; $display("FAIL full_single_retire: got %b exp 0", ret_v); end
    endtask

    task automatic test_stream();
        int         allocated = 0;
        int         retired   = 0;
        int         prev_idx  = -1;
        bit         seen_wrap = 0;
        int         guard     = 0;
        bit         v;
        bit         c;
        logic [3:0] cidx;
        di_t        d;
        int         cand[$];
        do_reset();
        while (retired < 40 && guard < 3000) begin
            guard++;
            v = (allocated < 40) && ($urandom_range(0, 3) != 0);
            d = v ? rand_di() : '0;
            c = 0; cidx = '0;
            cand.delete();
            foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].idx);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                c = 1; cidx = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 7) == 0) begin
                c = 1; cidx = 4'($urandom_range(0, N - 1));
            end
            if (v && di_ready === 1'b1) begin
                allocated++;
                if (prev_idx == N - 1 && rob_idx === 4'd0) seen_wrap = 1;
                prev_idx = int'(rob_idx);
            end
            drive_cycle(v, d, c, cidx, 1'b0);
            checks++; if (ret_v !== 1'(m_ret_v)) begin errors++; $display("FAIL stream_ret_v: got %b exp %b cycle %0d", ret_v, m_ret_v, cyc); end
            if (m_ret_v) begin
                checks++; if (ret_e !== m_ret) begin errors++; $display("FAIL stream_ret_e: got %h exp %h", ret_e, m_ret); end
            end
            if (ret_v === 1'b1) retired++;
            checks++; if (rob_idx !== 4'(m_tail)) begin errors++; $display("FAIL stream_idx: got %0d exp %0d", rob_idx, m_tail); end
            checks++; if (di_ready !== 1'(mq.size() < N)) begin errors++; $display("FAIL stream_ready: got %b exp %b", di_ready, mq.size() < N); end
            checks++; if (dut.count_q > 5'd16 || int'(dut.count_q) != mq.size()) begin errors++; $display("FAIL stream_count: got %0d exp %0d", dut.count_q, mq.size()); end
        end
        checks++; if (retired != 40) begin errors++; $display("FAIL stream_retired: got %0d exp 40", retired); end
        checks++; if (!seen_wrap) begin errors++; $display("FAIL stream_wrap: got 0 exp 1"); end
    endtask

    task automatic test_squash();
        di_t d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = rand_di();
            drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        end
        drive_cycle(1'b0, '0, 1'b1, 4'd1, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 4'd3, 1'b0);
        d = rand_di();
        drive_cycle(1'b1, d, 1'b1, 4'd0, 1'b1);
        checks++; if (dut.count_q !== 5'd0) begin errors++; $display("FAIL squash_count: got %0d exp 0", dut.count_q); end
        checks++; if (di_ready !== 1'b1 || rob_idx !== 4'd0) begin errors++; $display("FAIL squash_ptrs: got ready=%b idx=%0d exp ready=1 idx=0", di_ready, rob_idx); end
        checks++; if (ret_v !== 1'b0) begin errors++; $display("FAIL squash_ret_v: got %b exp 0", ret_v); end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 4'(i % 5), 1'b0);
            checks++; if (ret_v !== 1'b0) begin errors++; $display("FAIL squash_no_retire: got %b exp 0 step %0d", ret_v, i); end
        end
        d = rand_di();
        drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        checks++; if (dut.count_q !== 5'd1 || rob_idx !== 4'd1) begin errors++; $display("FAIL squash_realloc: got count=%0d idx=%0d exp count=1 idx=1", dut.count_q, rob_idx); end
    endtask

    task automatic test_same_cycle();
        di_t        d;
        logic [7:0] first_id;
        do_reset();
        first_id = 8'(next_id);
        for (int i = 0; i < 3; i++) begin
            d = rand_di();
            drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        end
        drive_cycle(1'b0, '0, 1'b1, 4'd0, 1'b0);
        checks++; if (dut.count_q !== 5'd3) begin errors++; $display("FAIL same_count_before: got %0d exp 3", dut.count_q); end
        d = rand_di();
        drive_cycle(1'b1, d, 1'b1, 4'd7, 1'b0);
        checks++; if (dut.count_q !== 5'd3) begin errors++; $display("FAIL same_count_after: got %0d exp 3", dut.count_q); end
        checks++; if (ret_v !== 1'b1 || ret_e.id !== first_id) begin errors++; $display("FAIL same_retire: got v=%b id=%0d exp v=1 id=%0d", ret_v, ret_e.id, first_id); end
        checks++; if (dut.done_q[7] !== 1'b0) begin errors++; $display("FAIL same_invalid_done: got %b exp 0", dut.done_q[7]); end
        checks++; if (rob_idx !== 4'd4) begin errors++; $display("FAIL same_idx: got %0d exp 4", rob_idx); end
    endtask

    task automatic test_async_reset();
        di_t d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = rand_di();
            drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        end
        di_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dut.count_q !== 5'd0 || rob_idx !== 4'd0) begin errors++; $display("FAIL async_clear: got count=%0d idx=%0d exp 0 0", dut.count_q, rob_idx); end
        checks++; if (di_ready !== 1'b1 || ret_v !== 1'b0) begin errors++; $display("FAIL async_outputs: got ready=%b ret_v=%b exp 1 0", di_ready, ret_v); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++; if (rob_idx !== 4'd0) begin errors++; $display("FAIL async_first_idx: got %0d exp 0", rob_idx); end
        d = rand_di();
        drive_cycle(1'b1, d, 1'b0, 4'd0, 1'b0);
        checks++; if (rob_idx !== 4'd1 || dut.count_q !== 5'd1) begin errors++; $display("FAIL async_alloc: got idx=%0d count=%0d exp 1 1", rob_idx, dut.count_q); end
    endtask

    initial begin
        rst         = 1'b1;
        di_valid    = 1'b0;
        di          = '0;
        cv          = 1'b0;
        ci          = '0;
        sq_if.valid = 1'b0;
        model_reset();
        test_reset();
        test_fill();
        test_out_of_order();
        test_full_retire();
        test_stream();
        test_squash();
        test_same_cycle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
